// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcode and ALU function
// codes, sequencer states, and the decoded control bundle.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JAL  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] FS_PASSA = 4'b0000;
    localparam logic [3:0] FS_ADD   = 4'b0010;
    localparam logic [3:0] FS_SUB   = 4'b0101;
    localparam logic [3:0] FS_AND   = 4'b1000;
    localparam logic [3:0] FS_OR    = 4'b1001;
    localparam logic [3:0] FS_XOR   = 4'b1010;
    localparam logic [3:0] FS_PASSB = 4'b1100;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

    // jump: load PC from the branch target at the end of EXEC
    typedef struct packed {
        logic [3:0] fs;
        logic       mb;
        logic       md;
        logic       rw;
        logic       mp;
        logic       mw;
        logic       illegal;
        logic       jump;
    } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and the datapath / instruction memory.
//   imem_addr, instr_in : instruction fetch address and returned word
//   Z                   : datapath zero flag
//   PC                  : current instruction address (for link PC+1)
//   DR, SA, SB, FS      : register addresses and ALU function select
//   MB, MD, RW, MP, MW  : datapath mux selects and write strobes
interface control_unit_if;
    logic [5:0]  imem_addr;
    logic [15:0] instr_in;
    logic        Z;
    logic [5:0]  PC;
    logic [3:0]  DR;
    logic [3:0]  SA;
    logic [3:0]  SB;
    logic [3:0]  FS;
    logic        MB;
    logic        MD;
    logic        RW;
    logic        MP;
    logic        MW;

    modport master (
        output imem_addr, PC, DR, SA, SB, FS, MB, MD, RW, MP, MW,
        input  instr_in, Z
    );

    modport slave (
        input  imem_addr, PC, DR, SA, SB, FS, MB, MD, RW, MP, MW,
        output instr_in, Z
    );
endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of the IR opcode and sequencer state into the
// datapath control bundle.
//   op    : IR[15:12]
//   state : current sequencer state
//   z     : datapath zero flag (only consulted for BZ in EXEC)
//   ctrl  : decoded controls; all selects/strobes 0 outside EXEC/MEM
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    input  state_t     state,
    input  logic       z,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl    = '0;
        ctrl.fs = FS_PASSA;
        if (state == EXEC) begin
            case (op)
                OP_NOP:  ;
                OP_ADD:  begin ctrl.fs = FS_ADD; ctrl.rw = 1'b1; end
                OP_SUB:  begin ctrl.fs = FS_SUB; ctrl.rw = 1'b1; end
                OP_AND:  begin ctrl.fs = FS_AND; ctrl.rw = 1'b1; end
                OP_OR:   begin ctrl.fs = FS_OR;  ctrl.rw = 1'b1; end
                OP_XOR:  begin ctrl.fs = FS_XOR; ctrl.rw = 1'b1; end
                OP_LDI: begin
                    ctrl.fs = FS_PASSB;
                    ctrl.mb = 1'b1;
                    ctrl.rw = 1'b1;
                end
                OP_LD:   ;  // address phase only; write-back happens in MEM
                OP_ST:   ctrl.mw = 1'b1;
                OP_BZ:   ctrl.jump = z;
                OP_JMP:  ctrl.jump = 1'b1;
                OP_JAL: begin
                    ctrl.mp   = 1'b1;
                    ctrl.rw   = 1'b1;
                    ctrl.jump = 1'b1;
                end
                OP_HALT: ;
                default: ctrl.illegal = 1'b1;
            endcase
        end else if (state == MEM) begin
            // only LD ever reaches MEM
            ctrl.md = 1'b1;
            ctrl.rw = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 16-bit CPU datapath. Owns the 6-bit PC
// and the instruction register, fetches from a 64-word instruction memory
// and drives the datapath controls through the bus interface.
//   clk_main : clock, rising edge
//   reset    : synchronous active-high; also forces strobes/selects low
//   bus      : instruction fetch + datapath control (master side)
//   halted   : high while in HALT
//   illegal  : one-cycle pulse in EXEC of opcodes C..E
//
//   state  | meaning
//   FETCH  | imem_addr = PC, wait for instruction memory
//   DECODE | IR <- instr_in
//   EXEC   | decoded controls driven from IR, PC updated on exit
//   MEM    | LD write-back, PC <- PC+1 on exit
//   HALT   | absorbing until reset
module control_unit
    import cpu_pkg::*;
#(
    parameter int IMEM_LAT = 1
) (
    input  logic                  clk_main,
    input  logic                  reset,
    control_unit_if.master        bus,
    output logic                  halted,
    output logic                  illegal
);

    localparam logic [2:0] LAT_M1 = 3'(IMEM_LAT - 1);

    state_t      state, state_nxt;
    logic [5:0]  pc, pc_nxt;
    logic [15:0] ir;
    logic [2:0]  wait_cnt;
    logic [3:0]  op;
    logic [5:0]  target;
    ctrl_t       ctrl;

    assign op     = ir[15:12];
    assign target = {ir[9:8], ir[3:0]};

    instr_decoder u_decoder (
        .op    (op),
        .state (state),
        .z     (bus.Z),
        .ctrl  (ctrl)
    );

    always_ff @(posedge clk_main) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= '0;
            ir       <= '0;
            wait_cnt <= LAT_M1;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == DECODE) ir <= bus.instr_in;
            // fetch wait timer reloads whenever we are outside FETCH
            if (state != FETCH)         wait_cnt <= LAT_M1;
            else if (wait_cnt != 3'd0)  wait_cnt <= wait_cnt - 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            FETCH:  if (wait_cnt == 3'd0) state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC: begin
                if (op == OP_LD)        state_nxt = MEM;
                else if (op == OP_HALT) state_nxt = HALT;
                else                    state_nxt = FETCH;
                // LD advances on MEM exit; HALT keeps pointing at itself
                if (ctrl.jump)                          pc_nxt = target;
                else if (op != OP_LD && op != OP_HALT)  pc_nxt = pc + 6'd1;
            end
            MEM: begin
                state_nxt = FETCH;
                pc_nxt    = pc + 6'd1;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    assign bus.imem_addr = pc;
    assign bus.PC        = pc;
    assign bus.DR        = ir[11:8];
    assign bus.SA        = ir[7:4];
    assign bus.SB        = ir[3:0];
    assign bus.FS        = ctrl.fs;
    assign bus.MB        = ctrl.mb & ~reset;
    assign bus.MD        = ctrl.md & ~reset;
    assign bus.RW        = ctrl.rw & ~reset;
    assign bus.MP        = ctrl.mp & ~reset;
    assign bus.MW        = ctrl.mw & ~reset;
    assign illegal       = ctrl.illegal & ~reset;
    assign halted        = (state == HALT) & ~reset;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic clk_main;
    logic reset;
    logic halted;
    logic illegal;
    logic [15:0] mem [64];
    logic [4:0] ctl;
    int n_pass;
    int n_total;

    control_unit_if bus();

    control_unit #(.IMEM_LAT(1)) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .bus      (bus),
        .halted   (halted),
        .illegal  (illegal)
    );

    assign ctl = {bus.MB, bus.MD, bus.RW, bus.MP, bus.MW};

    initial clk_main = 1'b0;
    always #5 clk_main = ~clk_main;

    // instruction memory, one-cycle read latency
    always @(posedge clk_main) bus.instr_in <= mem[bus.imem_addr];

    task automatic cyc();
        @(negedge clk_main);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.Z = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = 16'h1123;
        reset = 1'b1;
        bus.Z = 1'b0;
        repeat (3) cyc();
        n_total++;
        if (bus.PC !== 6'd0 || bus.imem_addr !== 6'd0)
            $display("FAIL reset_pc got pc=%0d addr=%0d want 0", bus.PC, bus.imem_addr);
        else n_pass++;
        n_total++;
        if (ctl !== 5'b0 || halted !== 1'b0 || illegal !== 1'b0)
            $display("FAIL reset_ctl got ctl=%b halted=%b illegal=%b want 0", ctl, halted, illegal);
        else n_pass++;
        n_total++;
        if (bus.DR !== 4'h0 || bus.FS !== 4'h0)
            $display("FAIL reset_ir got DR=%h FS=%b want 0", bus.DR, bus.FS);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_ldi();
        clear_mem();
        mem[0] = 16'h6A12;
        do_reset();
        cyc();
        n_total++;
        if (ctl !== 5'b0) $display("FAIL ldi_decode_ctl got %b want 00000", ctl);
        else n_pass++;
        cyc();
        n_total++;
        if (ctl !== 5'b10100 || bus.FS !== 4'b1100 || bus.DR !== 4'hA)
            $display("FAIL ldi_exec got ctl=%b FS=%b DR=%h want 10100 1100 a", ctl, bus.FS, bus.DR);
        else n_pass++;
        cyc();
        n_total++;
        if (bus.PC !== 6'd1 || ctl !== 5'b0)
            $display("FAIL ldi_next got pc=%0d ctl=%b want 1 00000", bus.PC, ctl);
        else n_pass++;
    endtask

    task automatic test_ld();
        clear_mem();
        mem[0] = 16'h7345;
        do_reset();
        cyc();
        cyc();
        n_total++;
        if (ctl !== 5'b0 || bus.FS !== 4'b0000)
            $display("FAIL ld_exec got ctl=%b FS=%b want 00000 0000", ctl, bus.FS);
        else n_pass++;
        cyc();
        n_total++;
        if (ctl !== 5'b01100 || bus.DR !== 4'h3)
            $display("FAIL ld_mem got ctl=%b DR=%h want 01100 3", ctl, bus.DR);
        else n_pass++;
        cyc();
        n_total++;
        if (bus.imem_addr !== 6'd1 || ctl !== 5'b0)
            $display("FAIL ld_next got addr=%0d ctl=%b want 1 00000", bus.imem_addr, ctl);
        else n_pass++;
    endtask

    task automatic test_bz();
        clear_mem();
        mem[0] = 16'h920A;  // BZ T=0x2A
        do_reset();
        bus.Z = 1'b1;
        cyc();
        cyc();
        n_total++;
        if (ctl !== 5'b0 || bus.FS !== 4'b0000)
            $display("FAIL bz_exec got ctl=%b FS=%b want 00000 0000", ctl, bus.FS);
        else n_pass++;
        cyc();
        n_total++;
        if (bus.imem_addr !== 6'h2A)
            $display("FAIL bz_taken got addr=%h want 2a", bus.imem_addr);
        else n_pass++;

        // Z high before EXEC but low in EXEC: not taken
        do_reset();
        bus.Z = 1'b1;
        cyc();
        bus.Z = 1'b0;
        cyc();
        cyc();
        n_total++;
        if (bus.imem_addr !== 6'd1)
            $display("FAIL bz_not_taken got addr=%0d want 1", bus.imem_addr);
        else n_pass++;

        // branch to itself keeps looping
        mem[0] = 16'h9000;
        do_reset();
        bus.Z = 1'b1;
        repeat (6) cyc();
        n_total++;
        if (bus.imem_addr !== 6'd0)
            $display("FAIL bz_self_loop got addr=%0d want 0", bus.imem_addr);
        else n_pass++;
        bus.Z = 1'b0;
    endtask

    task automatic test_jal();
        clear_mem();
        mem[0] = 16'hA007;  // JMP 7
        mem[7] = 16'hB535;  // JAL R5, T=0x15
        do_reset();
        repeat (3) cyc();
        n_total++;
        if (bus.imem_addr !== 6'd7)
            $display("FAIL jmp_target got addr=%0d want 7", bus.imem_addr);
        else n_pass++;
        cyc();
        cyc();
        n_total++;
        if (ctl !== 5'b00110 || bus.DR !== 4'h5 || bus.PC !== 6'd7)
            $display("FAIL jal_exec got ctl=%b DR=%h pc=%0d want 00110 5 7", ctl, bus.DR, bus.PC);
        else n_pass++;
        cyc();
        n_total++;
        if (bus.imem_addr !== 6'h15 || ctl !== 5'b0)
            $display("FAIL jal_next got addr=%h ctl=%b want 15 00000", bus.imem_addr, ctl);
        else n_pass++;
    endtask

    task automatic test_wrap();
        clear_mem();
        mem[0] = 16'hA30F;  // JMP 63
        do_reset();
        repeat (3) cyc();
        n_total++;
        if (bus.imem_addr !== 6'd63)
            $display("FAIL wrap_at63 got addr=%0d want 63", bus.imem_addr);
        else n_pass++;
        repeat (3) cyc();
        n_total++;
        if (bus.imem_addr !== 6'd0)
            $display("FAIL wrap_to0 got addr=%0d want 0", bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_illegal();
        clear_mem();
        mem[0] = 16'hC123;
        mem[1] = 16'hE000;
        do_reset();
        cyc();
        n_total++;
        if (illegal !== 1'b0) $display("FAIL illegal_decode got %b want 0", illegal);
        else n_pass++;
        cyc();
        n_total++;
        if (illegal !== 1'b1 || ctl !== 5'b0)
            $display("FAIL illegal_exec got illegal=%b ctl=%b want 1 00000", illegal, ctl);
        else n_pass++;
        cyc();
        n_total++;
        if (illegal !== 1'b0 || bus.PC !== 6'd1)
            $display("FAIL illegal_after got illegal=%b pc=%0d want 0 1", illegal, bus.PC);
        else n_pass++;
        cyc();
        cyc();
        n_total++;
        if (illegal !== 1'b1) $display("FAIL illegal_op_e got %b want 1", illegal);
        else n_pass++;
    endtask

    task automatic test_halt();
        int bad;
        clear_mem();
        mem[0] = 16'hF000;
        do_reset();
        cyc();
        cyc();
        n_total++;
        if (halted !== 1'b0) $display("FAIL halt_exec got %b want 0", halted);
        else n_pass++;
        cyc();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (halted !== 1'b1 || bus.RW !== 1'b0 || bus.MW !== 1'b0) bad++;
            cyc();
        end
        n_total++;
        if (bad !== 0) $display("FAIL halt_hold got %0d bad cycles want 0", bad);
        else n_pass++;
        reset = 1'b1;
        cyc();
        n_total++;
        if (halted !== 1'b0 || bus.PC !== 6'd0)
            $display("FAIL halt_reset got halted=%b pc=%0d want 0 0", halted, bus.PC);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_reset_in_st();
        clear_mem();
        mem[0] = 16'h8012;
        do_reset();
        cyc();
        cyc();
        n_total++;
        if (ctl !== 5'b00001) $display("FAIL st_exec got ctl=%b want 00001", ctl);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.MW !== 1'b0) $display("FAIL st_reset_mw got %b want 0", bus.MW);
        else n_pass++;
        cyc();
        n_total++;
        if (bus.PC !== 6'd0 || bus.MW !== 1'b0)
            $display("FAIL st_reset_pc got pc=%0d MW=%b want 0 0", bus.PC, bus.MW);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_fs [5];
        logic [3:0] exp_dr [5];
        clear_mem();
        mem[0] = 16'h1123;
        mem[1] = 16'h2456;
        mem[2] = 16'h3789;
        mem[3] = 16'h4B00;
        mem[4] = 16'h5C00;
        exp_fs = '{4'b0010, 4'b0101, 4'b1000, 4'b1001, 4'b1010};
        exp_dr = '{4'h1, 4'h4, 4'h7, 4'hB, 4'hC};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc();
            cyc();
            n_total++;
            if (bus.FS !== exp_fs[i] || bus.DR !== exp_dr[i] || ctl !== 5'b00100
                || bus.PC !== 6'(i))
                $display("FAIL alu_%0d got FS=%b DR=%h ctl=%b pc=%0d want %b %h 00100 %0d",
                         i, bus.FS, bus.DR, ctl, bus.PC, exp_fs[i], exp_dr[i], i);
            else n_pass++;
            cyc();
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        bus.Z   = 1'b0;
        test_reset();
        test_ldi();
        test_ld();
        test_bz();
        test_jal();
        test_wrap();
        test_illegal();
        test_halt();
        test_reset_in_st();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
